controlador_nivel: RTL and testbench

CONTROLADOR_NIVEL -- requirements
Module: controlador_nivel

---
 rtl/controlador_nivel.sv | 165 ++++++++++++++++
 tb/tb_controlador_nivel.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_nivel.sv
// Hunger/health level controller: debounced food/medicine buttons arbitrate
// service grants that raise Nivel/Salud, while a free-running decay lowers them.
module controlador_nivel #(
  parameter int unsigned TICKS_DECAY = 50_000_000,
  parameter int unsigned TICKS_DOSIS = 25_000_000,
  parameter int unsigned DEBOUNCE    = 16,
  parameter int unsigned COOLDOWN    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Boton_Comida,
  input  logic       Boton_Medicina,
  input  logic       Pausa,
  output logic [1:0] Nivel,
  output logic [1:0] Salud,
  output logic [1:0] Atendiendo,
  output logic [1:0] Estado,
  output logic       Evento_Hambre
);

  localparam int unsigned DEC_W = (TICKS_DECAY > 1) ? $clog2(TICKS_DECAY) : 1;
  localparam int unsigned DOS_W = (TICKS_DOSIS > 1) ? $clog2(TICKS_DOSIS) : 1;
  localparam int unsigned DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(TICKS_DECAY - 1);
  localparam logic [DOS_W-1:0] DOS_LAST = DOS_W'(TICKS_DOSIS - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
  localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    ALIMENTANDO = 2'b01,
    MEDICANDO   = 2'b10,
    ESPERA      = 2'b11
  } estado_t;

  // Bit 0 = food, bit 1 = medicine throughout the button path.
  logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]            deb_q, deb_d, rise;
  logic [1:0][DEB_W-1:0] db_cnt_q, db_cnt_d;

  estado_t          state_q, state_d;
  logic [DEC_W-1:0] dec_q, dec_d;
  logic [DOS_W-1:0] dose_q, dose_d;
  logic [CD_W-1:0]  cool_q, cool_d;
  logic [1:0]       nivel_q, nivel_d, salud_q, salud_d;
  logic             evento_q, evento_d;

  logic       in_service, granted_held, leave, dose_wrap, dec_run, dec_wrap;
  logic       salud_inc, salud_dec;
  logic [1:0] served;

  // Returns {debounced value, counter}; the value flips after DEBOUNCE
  // consecutive cycles of disagreement with the synchronized input.
  function automatic logic [DEB_W:0] debounce(input logic s, input logic d,
                                              input logic [DEB_W-1:0] c);
    logic [DEB_W:0] r;
    r = {d, {DEB_W{1'b0}}};
    if (s != d) begin
      if (c == DEB_LAST) r = {s, {DEB_W{1'b0}}};
      else               r = {d, c + DEB_W'(1)};
    end
    return r;
  endfunction

  always_comb begin
    sync1_d = {Boton_Medicina, Boton_Comida};
    sync2_d = sync1_q;
    {deb_d[0], db_cnt_d[0]} = debounce(sync2_q[0], deb_q[0], db_cnt_q[0]);
    {deb_d[1], db_cnt_d[1]} = debounce(sync2_q[1], deb_q[1], db_cnt_q[1]);
    rise = deb_d & ~deb_q;
  end

  always_comb begin
    state_d  = state_q;
    dec_d    = dec_q;
    dose_d   = '0;
    cool_d   = '0;
    nivel_d  = nivel_q;
    salud_d  = salud_q;

    in_service   = (state_q == ALIMENTANDO) || (state_q == MEDICANDO);
    served       = (state_q == ALIMENTANDO) ? nivel_q : salud_q;
    granted_held = (state_q == ALIMENTANDO) ? deb_q[0] : deb_q[1];
    leave        = in_service && (!granted_held || served == 2'd3);

    dose_wrap = 1'b0;
    if (in_service && !leave) begin
      if (dose_q == DOS_LAST) dose_wrap = 1'b1;
      else                    dose_d    = dose_q + DOS_W'(1);
    end

    dec_run  = !Pausa && (state_q != ALIMENTANDO);
    dec_wrap = dec_run && (dec_q == DEC_LAST);
    if (dec_run) dec_d = dec_wrap ? '0 : dec_q + DEC_W'(1);

    unique case (state_q)
      IDLE: begin
        if (rise[1] && salud_q != 2'd3)      state_d = MEDICANDO;
        else if (rise[0] && nivel_q != 2'd3) state_d = ALIMENTANDO;
      end
      ALIMENTANDO, MEDICANDO: begin
        if (leave) state_d = ESPERA;
      end
      ESPERA: begin
        if (cool_q == CD_LAST) state_d = IDLE;
        else                   cool_d  = cool_q + CD_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Decay never runs while feeding, so the two Nivel sources are exclusive.
    if (dose_wrap && state_q == ALIMENTANDO && nivel_q != 2'd3)
      nivel_d = nivel_q + 2'd1;
    else if (dec_wrap && nivel_q != 2'd0)
      nivel_d = nivel_q - 2'd1;

    // A simultaneous heal and starvation hit cancel each other out.
    salud_inc = dose_wrap && (state_q == MEDICANDO);
    salud_dec = dec_wrap && (nivel_q == 2'd0);
    if (salud_inc && !salud_dec && salud_q != 2'd3)
      salud_d = salud_q + 2'd1;
    else if (salud_dec && !salud_inc && salud_q != 2'd0)
      salud_d = salud_q - 2'd1;

    evento_d = (nivel_q != 2'd0) && (nivel_d == 2'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      db_cnt_q <= '0;
      state_q  <= IDLE;
      dec_q    <= '0;
      dose_q   <= '0;
      cool_q   <= '0;
      nivel_q  <= 2'd3;
      salud_q  <= 2'd3;
      evento_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      dec_q    <= dec_d;
      dose_q   <= dose_d;
      cool_q   <= cool_d;
      nivel_q  <= nivel_d;
      salud_q  <= salud_d;
      evento_q <= evento_d;
    end
  end

  assign Nivel         = nivel_q;
  assign Salud         = salud_q;
  assign Estado        = state_q;
  assign Evento_Hambre = evento_q;
  assign Atendiendo    = (state_q == ALIMENTANDO) ? 2'b01 :
                         (state_q == MEDICANDO)   ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_controlador_nivel.sv
// Scoreboard bench for controlador_nivel: a window/arithmetic reference model
// predicts every post-edge output; a monitor compares them one cycle at a time.
module tb_controlador_nivel;

  localparam int TD = 10;
  localparam int TS = 4;
  localparam int DB = 2;
  localparam int CD = 3;

  logic       clk;
  logic       reset;
  logic       Boton_Comida, Boton_Medicina, Pausa;
  logic [1:0] Nivel, Salud, Atendiendo, Estado;
  logic       Evento_Hambre;

  controlador_nivel #(
    .TICKS_DECAY(TD),
    .TICKS_DOSIS(TS),
    .DEBOUNCE   (DB),
    .COOLDOWN   (CD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Boton_Comida  (Boton_Comida),
    .Boton_Medicina(Boton_Medicina),
    .Pausa         (Pausa),
    .Nivel         (Nivel),
    .Salud         (Salud),
    .Atendiendo    (Atendiendo),
    .Estado        (Estado),
    .Evento_Hambre (Evento_Hambre)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] v;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model state. States: 0 idle, 1 feeding, 2 medicating, 3 cooldown.
  int m_state, m_nivel, m_salud, m_dec, m_dose, m_cool;
  bit m_evt;
  bit m_deb[2];
  bit h_com[$];
  bit h_med[$];

  function automatic int clamp3(input int x);
    return (x < 0) ? 0 : ((x > 3) ? 3 : x);
  endfunction

  // Raw history h[0..DB-1] covers the synchronized samples seen on the last
  // DB edges; the debounced value flips only if all of them disagree with it.
  function automatic bit flips(input bit h[$], input bit d);
    for (int k = 0; k < DB; k++)
      if (h[k] == d) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_nivel = 3; m_salud = 3;
    m_dec = 0; m_dose = 0; m_cool = 0; m_evt = 1'b0;
    m_deb[0] = 1'b0; m_deb[1] = 1'b0;
    h_com.delete(); h_med.delete();
    for (int k = 0; k < DB + 1; k++) begin
      h_com.push_back(1'b0);
      h_med.push_back(1'b0);
    end
  endfunction

  function automatic void model_step(input bit rc, input bit rm, input bit p);
    bit nd[2];
    bit rise[2];
    bit in_svc, held, leave, dose_wrap, run, dwrap;
    int served, dn, ds, nn, ns, nstate;

    h_com.push_back(rc); if (h_com.size() > DB + 2) void'(h_com.pop_front());
    h_med.push_back(rm); if (h_med.size() > DB + 2) void'(h_med.pop_front());
    nd[0] = flips(h_com, m_deb[0]) ? !m_deb[0] : m_deb[0];
    nd[1] = flips(h_med, m_deb[1]) ? !m_deb[1] : m_deb[1];
    rise[0] = nd[0] && !m_deb[0];
    rise[1] = nd[1] && !m_deb[1];

    in_svc    = (m_state == 1) || (m_state == 2);
    held      = (m_state == 1) ? m_deb[0] : m_deb[1];
    served    = (m_state == 1) ? m_nivel : m_salud;
    leave     = in_svc && (!held || served == 3);
    dose_wrap = in_svc && !leave && (m_dose == TS - 1);
    run       = !p && (m_state != 1);
    dwrap     = run && (m_dec == TD - 1);

    dn = 0; ds = 0;
    if (dose_wrap && m_state == 1) dn += 1;
    if (dwrap && m_nivel > 0)      dn -= 1;
    if (dose_wrap && m_state == 2) ds += 1;
    if (dwrap && m_nivel == 0)     ds -= 1;
    nn = clamp3(m_nivel + dn);
    ns = clamp3(m_salud + ds);

    nstate = m_state;
    case (m_state)
      0: begin
        if (rise[1] && m_salud < 3)      begin nstate = 2; m_dose = 0; end
        else if (rise[0] && m_nivel < 3) begin nstate = 1; m_dose = 0; end
      end
      1, 2: begin
        if (leave) begin nstate = 3; m_cool = 0; end
        else m_dose = (m_dose + 1) % TS;
      end
      default: begin
        if (m_cool == CD - 1) nstate = 0;
        else m_cool++;
      end
    endcase
    if (run) m_dec = (m_dec + 1) % TD;

    m_evt   = (m_nivel > 0) && (nn == 0);
    m_nivel = nn;
    m_salud = ns;
    m_state = nstate;
    m_deb   = nd;
  endfunction

  function automatic void push_exp();
    exp_t e;
    int   aten;
    aten  = (m_state == 1) ? 1 : ((m_state == 2) ? 2 : 0);
    e.v   = {2'(m_nivel), 2'(m_salud), 2'(aten), 2'(m_state), m_evt};
    e.cyc = cyc;
    sb.push_back(e);
  endfunction

  task automatic tick(input bit c, input bit m, input bit p);
    @(negedge clk);
    Boton_Comida = c; Boton_Medicina = m; Pausa = p;
    cyc++;
    model_step(c, m, p);
    push_exp();
  endtask

  task automatic do_reset(input int n, input bit c, input bit m);
    @(negedge clk);
    reset = 1'b0; Boton_Comida = c; Boton_Medicina = m; Pausa = 1'b0;
    cyc++;
    model_reset();
    push_exp();
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      cyc++;
      push_exp();
    end
    @(negedge clk);
    reset = 1'b1;
    cyc++;
    model_step(c, m, 1'b0);
    push_exp();
  endtask

  initial begin : monitor
    exp_t       e;
    logic [8:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {Nivel, Salud, Atendiendo, Estado, Evento_Hambre};
        n_checks++;
        if (got === e.v) n_pass++;
        else $display("FAIL outputs cyc=%0d got niv=%0d sal=%0d aten=%b est=%b evt=%b expected niv=%0d sal=%0d aten=%b est=%b evt=%b",
                      e.cyc, got[8:7], got[6:5], got[4:3], got[2:1], got[0],
                      e.v[8:7], e.v[6:5], e.v[4:3], e.v[2:1], e.v[0]);
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; Boton_Comida = 1'b0; Boton_Medicina = 1'b0; Pausa = 1'b0;
    model_reset();

    // Idle decay through starvation and health saturation.
    do_reset(2, 0, 0);
    repeat (70) tick(0, 0, 0);

    // Feeding from Nivel=1 to full while the button stays held.
    do_reset(1, 0, 0);
    repeat (20) tick(0, 0, 0);
    repeat (30) tick(1, 0, 0);
    repeat (10) tick(0, 0, 0);

    // Arbitration: both buttons together, food re-pressed during medication.
    do_reset(1, 0, 0);
    repeat (50) tick(0, 0, 0);
    for (int k = 0; k < 40 && m_nivel != 1; k++) tick(1, 0, 0);
    for (int k = 0; k < 40 && m_state != 0; k++) tick(0, 0, 0);
    repeat (5) tick(1, 1, 0);
    repeat (3) tick(0, 1, 0);
    repeat (20) tick(1, 1, 0);
    repeat (12) tick(0, 0, 0);

    // Decay and dose wraps aligned, first with Nivel=2 then with Nivel=0.
    do_reset(1, 0, 0);
    repeat (50) tick(0, 0, 0);
    for (int k = 0; k < 80 && m_state != 3; k++) tick(1, 0, 0);
    for (int k = 0; k < 40 && m_state != 0; k++) tick(0, 0, 0);
    for (int k = 0; k < 100 && !(m_state == 0 && m_nivel == 2 && m_dec == TD - 8); k++)
      tick(0, 0, 0);
    repeat (30) tick(0, 1, 0);
    for (int k = 0; k < 200 && !(m_state == 0 && m_nivel == 0 && m_salud < 3 && m_dec == TD - 8); k++)
      tick(0, 0, 0);
    repeat (30) tick(0, 1, 0);
    repeat (5) tick(0, 0, 0);

    // Pause hold, single-cycle glitch, reset mid-feed with the button held.
    do_reset(1, 0, 0);
    repeat (5) tick(0, 0, 0);
    repeat (25) tick(0, 0, 1);
    repeat (15) tick(0, 0, 0);
    tick(1, 0, 0);
    repeat (10) tick(0, 0, 0);
    repeat (7) tick(1, 0, 0);
    do_reset(1, 1, 0);
    repeat (20) tick(1, 0, 0);
    repeat (15) tick(0, 0, 0);

    // Randomized traffic.
    for (int it = 0; it < 160; it++) begin
      bit c, m, p;
      int len;
      c   = 1'($urandom_range(0, 1));
      m   = ($urandom_range(0, 2) == 0);
      p   = ($urandom_range(0, 5) == 0);
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 40) == 0) do_reset($urandom_range(1, 3), c, m);
      else if ($urandom_range(0, 6) == 0) begin
        tick(!c, m, p);
        tick(c, m, p);
      end else
        repeat (len) tick(c, m, p);
    end
    repeat (5) tick(0, 0, 0);

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d expected pending=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
